// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms, rings, snoozes and times out an alarm event.
// Sits between the clock/adjust stage and the buzzer.
module alarm_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm,
    input  logic       snooze,
    input  logic       dismiss,
    input  logic [4:0] time_hours,
    input  logic [5:0] time_minutes,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic       buzzer_en,
    output logic [1:0] state,
    output logic [4:0] wake_hours,
    output logic [5:0] wake_minutes,
    output logic [1:0] snooze_cnt
);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_RINGING  = 2'd2;
    localparam logic [1:0] ST_SNOOZED  = 2'd3;

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = $clog2(RING_SEC + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
    localparam logic [1:0]    SNZ_LIMIT = 2'(MAX_SNOOZE);

    logic [TW-1:0] tick_cnt_r;
    logic          tick_s;
    logic [RW-1:0] ring_cnt_r;
    logic [RW-1:0] ring_nxt_s;
    logic          match_s;
    logic          match_q_r;
    logic          trigger_s;
    logic [1:0]    state_nxt_s;
    logic [1:0]    cnt_nxt_s;
    logic [4:0]    wake_h_nxt_s;
    logic [5:0]    wake_m_nxt_s;
    logic [10:0]   snoozed_s;

    // Wake time plus SNOOZE_MIN minutes, wrapping 23:59 -> 00:00.
    function automatic logic [10:0] add_snooze(input logic [4:0] h, input logic [5:0] m);
        logic [6:0] m_sum;
        logic [4:0] h_sum;
        m_sum = {1'b0, m} + 7'(SNOOZE_MIN);
        h_sum = h;
        if (m_sum >= 7'd60) begin
            m_sum = m_sum - 7'd60;
            h_sum = h + 5'd1;
        end else begin
            h_sum = h;
        end
        if (h_sum == 5'd24) begin
            h_sum = 5'd0;
        end else begin
            h_sum = h_sum;
        end
        return {h_sum, m_sum[5:0]};
    endfunction

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign match_s   = (time_hours == wake_hours) && (time_minutes == wake_minutes);
    assign trigger_s = match_s & ~match_q_r;
    assign snoozed_s = add_snooze(wake_hours, wake_minutes);

    // Free-running one-second tick divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Next-state, target, ring-counter and snooze-count decisions.
    always_comb begin
        state_nxt_s  = state;
        cnt_nxt_s    = snooze_cnt;
        ring_nxt_s   = ring_cnt_r;
        wake_h_nxt_s = wake_hours;
        wake_m_nxt_s = wake_minutes;
        case (state)
            ST_DISARMED: begin
                wake_h_nxt_s = alarm_hours;
                wake_m_nxt_s = alarm_minutes;
                if (arm) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_DISARMED;
                end
            end
            ST_ARMED: begin
                wake_h_nxt_s = alarm_hours;
                wake_m_nxt_s = alarm_minutes;
                if (!arm) begin
                    state_nxt_s = ST_DISARMED;
                end else if (trigger_s) begin
                    state_nxt_s = ST_RINGING;
                    ring_nxt_s  = '0;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (!arm) begin
                    state_nxt_s = ST_DISARMED;
                end else if (dismiss) begin
                    state_nxt_s = ST_ARMED;
                end else if (snooze || (tick_s && (ring_cnt_r == RING_LAST))) begin
                    if (snooze_cnt == SNZ_LIMIT) begin
                        state_nxt_s = ST_ARMED;
                        cnt_nxt_s   = 2'd0;
                    end else begin
                        state_nxt_s  = ST_SNOOZED;
                        cnt_nxt_s    = snooze_cnt + 2'd1;
                        wake_h_nxt_s = snoozed_s[10:6];
                        wake_m_nxt_s = snoozed_s[5:0];
                    end
                end else if (tick_s) begin
                    ring_nxt_s = ring_cnt_r + RW'(1);
                end else begin
                    ring_nxt_s = ring_cnt_r;
                end
            end
            ST_SNOOZED: begin
                if (!arm) begin
                    state_nxt_s = ST_DISARMED;
                end else if (dismiss) begin
                    state_nxt_s = ST_ARMED;
                    cnt_nxt_s   = 2'd0;
                end else if (trigger_s) begin
                    state_nxt_s = ST_RINGING;
                    ring_nxt_s  = '0;
                end else begin
                    state_nxt_s = ST_SNOOZED;
                end
            end
            default: begin
                state_nxt_s = ST_DISARMED;
            end
        endcase
    end

    // Registered outputs; buzzer follows the state register on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_DISARMED;
            buzzer_en    <= 1'b0;
            wake_hours   <= 5'd0;
            wake_minutes <= 6'd0;
            snooze_cnt   <= 2'd0;
            ring_cnt_r   <= '0;
            match_q_r    <= 1'b0;
        end else begin
            state        <= state_nxt_s;
            buzzer_en    <= (state_nxt_s == ST_RINGING);
            wake_hours   <= wake_h_nxt_s;
            wake_minutes <= wake_m_nxt_s;
            snooze_cnt   <= cnt_nxt_s;
            ring_cnt_r   <= ring_nxt_s;
            match_q_r    <= match_s;
        end
    end

endmodule
